sample_tick_gen: RTL and testbench

- Programmable, phase-adjustable sample-timing generator for the optical receiver.
- Replaces the fixed-ratio slow sample clock with three registered outputs in the system clock domain: a square sample_level, a one-cycle tick at each period start, and a one-cycle mid_tick at mid-period.
- Period can be reloaded at runtime. Phase can be nudged one cycle at a time, so the closed-loop receiver can align sampling to bit centres.

---
 rtl/sample_tick_gen.sv | 104 ++++++++++
 tb/tb_sample_tick_gen.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_tick_gen.sv
// Programmable, phase-adjustable sample-timing generator in the system clock domain.
// Latency: all outputs registered from next_count; first tick at edge P after reset release.
// Backpressure: none; enable=0 freezes the counter, while period loads are still captured.
//
// Ports:
//   clock, reset       system clock and synchronous active-high reset
//   enable             count enable (counter holds when low, adjust pulses ignored)
//   div_load/div_value request a new period, applied at the next wrap (clamped to >= 4)
//   div_pending        a loaded period is waiting for the next wrap
//   phase_adv/ret      one-cycle pulses: skip one count / hold one count
//   tick, mid_tick     one-cycle pulses at period start and at mid-period
//   sample_level       high while count < P/2
//   period             currently active period P
module sample_tick_gen #(
    parameter int CNT_W       = 22,
    parameter int DEFAULT_DIV = 12
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             div_load,
    input  logic [CNT_W-1:0] div_value,
    output logic             div_pending,
    input  logic             phase_adv,
    input  logic             phase_ret,
    output logic             tick,
    output logic             mid_tick,
    output logic             sample_level,
    output logic [CNT_W-1:0] period
);

    localparam logic [CNT_W-1:0] DEF_P   = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] MIN_DIV = CNT_W'(4);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] p_reg;
    logic [CNT_W-1:0] pend_val;
    logic             pend_flag;

    logic [CNT_W-1:0] next_count;
    logic [CNT_W-1:0] mid_pt;
    logic [CNT_W-1:0] load_val;
    logic [CNT_W:0]   sum;
    logic             advance;
    logic             hold;
    logic             wrap;
    logic             mid_hit;

    always_comb begin
        // Both adjust pulses together cancel into a plain step.
        advance    = enable & phase_adv & ~phase_ret;
        hold       = ~enable | (phase_ret & ~phase_adv);
        mid_pt     = p_reg >> 1;
        // One extra bit so count+2 cannot overflow before the modulo compare.
        sum        = {1'b0, count} + (advance ? (CNT_W+1)'(2) : (CNT_W+1)'(1));
        next_count = count;
        wrap       = 1'b0;
        if (!hold) begin
            if (sum >= {1'b0, p_reg}) begin
                next_count = CNT_W'(sum - {1'b0, p_reg});
                wrap       = 1'b1;
            end else begin
                next_count = sum[CNT_W-1:0];
            end
        end
        // The crossing test also catches an M that an advance jumped over.
        mid_hit  = !hold && (next_count >= mid_pt) && ((count < mid_pt) || wrap);
        load_val = (div_value < MIN_DIV) ? MIN_DIV : div_value;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count        <= '0;
            p_reg        <= DEF_P;
            pend_val     <= DEF_P;
            pend_flag    <= 1'b0;
            tick         <= 1'b0;
            mid_tick     <= 1'b0;
            sample_level <= 1'b0;
        end else begin
            count    <= next_count;
            tick     <= wrap;
            mid_tick <= mid_hit;
            // After a wrap next_count is 0 or 1, below any M >= 2, so comparing
            // against the outgoing period's midpoint is safe even on a reload.
            if (!hold) begin
                sample_level <= (next_count < mid_pt);
            end
            if (wrap && pend_flag) begin
                p_reg     <= pend_val;
                pend_flag <= 1'b0;
            end
            // A load on the wrap edge overrides the clear and waits for the next wrap.
            if (div_load) begin
                pend_val  <= load_val;
                pend_flag <= 1'b1;
            end
        end
    end

    assign period      = p_reg;
    assign div_pending = pend_flag;

endmodule

// File: tb/tb_sample_tick_gen.sv
module tb_sample_tick_gen;

    localparam int CNT_W = 22;
    localparam int DEF   = 12;

    logic             clock = 1'b0;
    logic             reset;
    logic             enable;
    logic             div_load;
    logic [CNT_W-1:0] div_value;
    logic             div_pending;
    logic             phase_adv;
    logic             phase_ret;
    logic             tick;
    logic             mid_tick;
    logic             sample_level;
    logic [CNT_W-1:0] period;

    sample_tick_gen #(.CNT_W(CNT_W), .DEFAULT_DIV(DEF)) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .div_load     (div_load),
        .div_value    (div_value),
        .div_pending  (div_pending),
        .phase_adv    (phase_adv),
        .phase_ret    (phase_ret),
        .tick         (tick),
        .mid_tick     (mid_tick),
        .sample_level (sample_level),
        .period       (period)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_tick = 0;
    int tick_gap = 0;

    // Reference model: position within the period as a plain integer.
    int m_count = 0;
    int m_p = DEF;
    int m_pv = DEF;
    bit m_pf = 0;
    bit m_tick = 0;
    bit m_mid = 0;
    bit m_lvl = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        int stp;
        int pos;
        int m;
        if (reset) begin
            m_count = 0; m_p = DEF; m_pv = DEF; m_pf = 0;
            m_tick = 0; m_mid = 0; m_lvl = 0;
            return;
        end
        if (!enable) stp = 0;
        else if (phase_adv && !phase_ret) stp = 2;
        else if (phase_ret && !phase_adv) stp = 0;
        else stp = 1;
        if (stp == 0) begin
            m_tick = 0;
            m_mid = 0;
        end else begin
            pos = m_count + stp;
            m = m_p / 2;
            // mid fires when the midpoint lies in the span of positions just traversed
            m_mid = (m > m_count) && (m <= pos);
            m_tick = (pos >= m_p);
            m_count = pos % m_p;
            m_lvl = (m_count < m);
            if (m_tick && m_pf) begin
                m_p = m_pv;
                m_pf = 0;
            end
        end
        if (div_load) begin
            m_pv = (int'(div_value) < 4) ? 4 : int'(div_value);
            m_pf = 1;
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_update();
        #1;
        cyc++;
        if (tick === 1'b1) begin
            tick_gap = cyc - last_tick;
            last_tick = cyc;
        end
        chk("tick", tick, m_tick);
        chk("mid_tick", mid_tick, m_mid);
        chk("sample_level", sample_level, m_lvl);
        chk("period", period, m_p);
        chk("div_pending", div_pending, m_pf);
    endtask

    task automatic wait_count(input int target);
        for (int k = 0; k < 100 && m_count != target; k++) step();
        if (m_count != target) begin
            errors++; checks++;
            $error("FAIL wait_count observed=%0d expected=%0d", m_count, target);
        end
    endtask

    task automatic gap_to_tick();
        bit seen;
        seen = 0;
        for (int k = 0; k < 100 && !seen; k++) begin
            step();
            if (tick === 1'b1) seen = 1;
        end
        if (!seen) begin
            errors++; checks++;
            $error("FAIL tick_timeout observed=0 expected=1");
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        cyc = 0;
        last_tick = 0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; div_load = 1'b0; div_value = '0;
        phase_adv = 1'b0; phase_ret = 1'b0;

        // Reset state and default stepping.
        do_reset();
        chk("rst_tick", tick, 0);
        chk("rst_mid", mid_tick, 0);
        chk("rst_level", sample_level, 0);
        chk("rst_period", period, 12);
        chk("rst_pending", div_pending, 0);
        for (int c = 1; c <= 14; c++) begin
            step();
            chk("def_tick", tick, (c % 12 == 0));
            chk("def_mid", mid_tick, (c % 12 == 6));
            chk("def_level", sample_level, (c % 12 < 6));
        end

        // Load 20, captured at edge 15; applied at the tick at 24.
        div_load = 1'b1; div_value = 22'd20;
        for (int c = 15; c <= 70; c++) begin
            step();
            div_load = 1'b0;
            chk("ld_tick", tick, (c == 24 || c == 36 - 12 || c == 44 || c == 64));
            chk("ld_period", period, (c >= 24) ? 20 : 12);
            chk("ld_pending", div_pending, (c >= 15 && c < 24));
        end

        // Reset mid-period with a load pending.
        wait_count(7);
        div_load = 1'b1; div_value = 22'd9;
        step();
        div_load = 1'b0;
        chk("pend_before_rst", div_pending, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        cyc = 0; last_tick = 0;
        chk("rst2_tick", tick, 0);
        chk("rst2_mid", mid_tick, 0);
        chk("rst2_level", sample_level, 0);
        chk("rst2_period", period, 12);
        chk("rst2_pending", div_pending, 0);
        gap_to_tick();
        chk("rst2_first_tick", tick_gap, 12);

        // Phase advance at count 11.
        wait_count(11);
        phase_adv = 1'b1;
        step();
        phase_adv = 1'b0;
        chk("adv_tick", tick, 1);
        gap_to_tick();
        chk("adv_gap", tick_gap, 11);

        // Phase retard at count 5.
        wait_count(5);
        phase_ret = 1'b1;
        step();
        phase_ret = 1'b0;
        chk("ret_mid_held", mid_tick, 0);
        step();
        chk("ret_mid_late", mid_tick, 1);
        gap_to_tick();
        chk("ret_gap", tick_gap, 13);

        // Both adjust pulses cancel.
        wait_count(3);
        phase_adv = 1'b1; phase_ret = 1'b1;
        step();
        phase_adv = 1'b0; phase_ret = 1'b0;
        gap_to_tick();
        chk("both_gap", tick_gap, 12);

        // Enable low for 5 cycles shifts everything by 5.
        wait_count(2);
        enable = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("dis_tick", tick, 0);
            chk("dis_mid", mid_tick, 0);
        end
        enable = 1'b1;
        gap_to_tick();
        chk("dis_gap", tick_gap, 17);

        // Clamp: a requested period of 1 becomes 4.
        div_load = 1'b1; div_value = 22'd1;
        step();
        div_load = 1'b0;
        chk("clamp_pending", div_pending, 1);
        gap_to_tick();
        chk("clamp_period", period, 4);
        step();
        step();
        chk("clamp_mid", mid_tick, 1);
        gap_to_tick();
        chk("clamp_gap1", tick_gap, 4);
        gap_to_tick();
        chk("clamp_gap2", tick_gap, 4);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            enable    = ($urandom_range(0, 9) != 0);
            phase_adv = ($urandom_range(0, 7) == 0);
            phase_ret = ($urandom_range(0, 7) == 0);
            div_load  = ($urandom_range(0, 29) == 0);
            div_value = 22'($urandom_range(0, 24));
            reset     = ($urandom_range(0, 499) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
